// File: rtl/ledr_pwm_driver_pkg.sv
// Register map and reset values shared by the LEDR PWM driver and its sub-blocks.
package ledr_pwm_driver_pkg;

    typedef enum logic [1:0] {
        RegCtrl  = 2'd0,
        RegDuty  = 2'd1,
        RegBmask = 2'd2,
        RegBper  = 2'd3
    } reg_addr_e;

    // Wide reset constants are sliced to the instance widths at the point of use.
    localparam logic        CTRL_RESET  = 1'b1;
    localparam logic [31:0] DUTY_RESET  = 32'hFFFF_FFFF;
    localparam logic [31:0] BMASK_RESET = 32'h0000_0000;
    localparam logic [15:0] BPER_RESET  = 16'h0000;

endpackage

// File: rtl/ledr_pwm_driver_if.sv
// Avalon-MM slave bus used by software to configure the LEDR PWM driver.
interface ledr_pwm_driver_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/ledr_pwm_timebase.sv
// Prescaler and PWM counter; flags the tick that ends each PWM period.
module ledr_pwm_timebase #(
    parameter int unsigned DUTY_W   = 8,
    parameter int unsigned PRESCALE = 196
) (
    input  logic              clk,
    input  logic              reset,
    output logic [DUTY_W-1:0] pwm_cnt,
    output logic              tick,
    output logic              period_strb
);

    localparam int unsigned     PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0] pre_cnt;

    assign tick        = (pre_cnt == PRE_MAX);
    assign period_strb = tick && (pwm_cnt == '1);

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt <= '0;
            pwm_cnt <= '0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
            if (tick) begin
                pwm_cnt <= pwm_cnt + DUTY_W'(1);
            end
        end
    end

endmodule

// File: rtl/ledr_pwm_driver.sv
// LEDR output stage: PWM dimming plus per-LED blink, configured over Avalon-MM.
module ledr_pwm_driver
    import ledr_pwm_driver_pkg::*;
#(
    parameter int unsigned WIDTH    = 18,
    parameter int unsigned DUTY_W   = 8,
    parameter int unsigned PRESCALE = 196
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   pattern_in,
    ledr_pwm_driver_if.slave   bus,
    output logic [WIDTH-1:0]   led_out,
    output logic               period_strb
);

    logic              en;
    logic [DUTY_W-1:0] duty;
    logic [WIDTH-1:0]  bmask;
    logic [15:0]       bper;

    logic [WIDTH-1:0]  sh_pat;
    logic [DUTY_W-1:0] sh_duty;
    logic [WIDTH-1:0]  sh_mask;

    logic [15:0]       blk_cnt;
    logic              blink_phase;

    logic [DUTY_W-1:0] pwm_cnt;
    logic              tick;
    logic              boundary;
    logic              wr;
    logic              bper_wr;
    logic [WIDTH-1:0]  led_d;
    logic [31:0]       rdata;

    ledr_pwm_timebase #(
        .DUTY_W   (DUTY_W),
        .PRESCALE (PRESCALE)
    ) u_timebase (
        .clk         (clk),
        .reset       (reset),
        .pwm_cnt     (pwm_cnt),
        .tick        (tick),
        .period_strb (period_strb)
    );

    assign boundary = tick && (pwm_cnt == '1);
    assign wr       = bus.chipselect && !bus.write_n;
    assign bper_wr  = wr && (bus.address == RegBper);

    always_ff @(posedge clk) begin
        if (reset) begin
            en    <= CTRL_RESET;
            duty  <= DUTY_RESET[DUTY_W-1:0];
            bmask <= BMASK_RESET[WIDTH-1:0];
            bper  <= BPER_RESET;
        end else if (wr) begin
            unique case (reg_addr_e'(bus.address))
                RegCtrl:  en    <= bus.writedata[0];
                RegDuty:  duty  <= bus.writedata[DUTY_W-1:0];
                RegBmask: bmask <= bus.writedata[WIDTH-1:0];
                RegBper:  bper  <= bus.writedata[15:0];
            endcase
        end
    end

    // Shadows sample the pre-write register values, so a same-cycle write lands one period later.
    always_ff @(posedge clk) begin
        if (reset) begin
            sh_pat  <= '0;
            sh_duty <= DUTY_RESET[DUTY_W-1:0];
            sh_mask <= '0;
        end else if (boundary) begin
            sh_pat  <= pattern_in;
            sh_duty <= duty;
            sh_mask <= bmask;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || bper_wr || (bper == '0)) begin
            blk_cnt     <= '0;
            blink_phase <= 1'b1;
        end else if (boundary) begin
            if (blk_cnt == bper - 16'd1) begin
                blk_cnt     <= '0;
                blink_phase <= !blink_phase;
            end else begin
                blk_cnt <= blk_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        led_d = sh_pat & ~(sh_mask & {WIDTH{!blink_phase}});
        if (!(en && (pwm_cnt < sh_duty))) begin
            led_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            led_out <= '0;
        end else begin
            led_out <= led_d;
        end
    end

    always_comb begin
        rdata = '0;
        unique case (reg_addr_e'(bus.address))
            RegCtrl:  rdata[0]          = en;
            RegDuty:  rdata[DUTY_W-1:0] = duty;
            RegBmask: rdata[WIDTH-1:0]  = bmask;
            RegBper:  rdata[15:0]       = bper;
        endcase
    end

    assign bus.readdata = rdata;

endmodule

// File: tb/tb_ledr_pwm_driver.sv
// Bench for ledr_pwm_driver: directed scenarios and random traffic against a period-level model.
module tb_ledr_pwm_driver;

    localparam int unsigned WIDTH     = 18;
    localparam int unsigned DUTY_W    = 8;
    localparam int unsigned PRESCALE  = 2;
    localparam int unsigned PWM_STEPS = 256;
    localparam int unsigned PERIOD    = PRESCALE * PWM_STEPS;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] pattern_in = '0;
    logic [WIDTH-1:0] led_out;
    logic             period_strb;

    ledr_pwm_driver_if bus ();

    ledr_pwm_driver #(
        .WIDTH    (WIDTH),
        .DUTY_W   (DUTY_W),
        .PRESCALE (PRESCALE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pattern_in  (pattern_in),
        .bus         (bus),
        .led_out     (led_out),
        .period_strb (period_strb)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: counters derived from elapsed cycles, blink phase from boundary count.
    int unsigned       n;
    int unsigned       bcount;
    logic              m_en;
    logic [DUTY_W-1:0] m_duty;
    logic [WIDTH-1:0]  m_bmask;
    logic [15:0]       m_bper;
    logic [WIDTH-1:0]  sh_pat;
    logic [DUTY_W-1:0] sh_duty;
    logic [WIDTH-1:0]  sh_mask;
    logic              last_strb;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit model_bnd();
        return (n % PERIOD) == PERIOD - 1;
    endfunction

    function automatic logic [WIDTH-1:0] model_led();
        int unsigned      pwm;
        logic             phase;
        logic [WIDTH-1:0] keep;
        pwm   = (n / PRESCALE) % PWM_STEPS;
        phase = (m_bper == '0) || (((bcount / 32'(m_bper)) % 2) == 0);
        keep  = phase ? {WIDTH{1'b1}} : ~sh_mask;
        if (m_en && (pwm < 32'(sh_duty))) return sh_pat & keep;
        return '0;
    endfunction

    task automatic model_reset();
        n       = 0;
        bcount  = 0;
        m_en    = 1'b1;
        m_duty  = '1;
        m_bmask = '0;
        m_bper  = '0;
        sh_pat  = '0;
        sh_duty = '1;
        sh_mask = '0;
    endtask

    task automatic cycle(input logic rst, input logic wr, input logic [1:0] a,
                         input logic [31:0] d);
        logic [WIDTH-1:0] exp_led;
        bit               bnd;
        reset          = rst;
        bus.chipselect = wr;
        bus.write_n    = !wr;
        bus.address    = a;
        bus.writedata  = d;
        last_strb      = period_strb;
        bnd            = model_bnd();
        if (!rst) check("period_strb", {31'b0, period_strb}, {31'b0, bnd});
        exp_led = rst ? '0 : model_led();
        if (rst) begin
            model_reset();
        end else begin
            if (bnd) begin
                sh_pat  = pattern_in;
                sh_duty = m_duty;
                sh_mask = m_bmask;
                if (m_bper != '0) bcount++;
            end
            if (wr) begin
                case (a)
                    2'd0: m_en = d[0];
                    2'd1: m_duty = d[DUTY_W-1:0];
                    2'd2: m_bmask = d[WIDTH-1:0];
                    default: begin
                        m_bper = d[15:0];
                        bcount = 0;
                    end
                endcase
            end
            n++;
        end
        @(posedge clk);
        #1;
        check("led_out", {14'b0, led_out}, {14'b0, exp_led});
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 2'd0, 32'h0);
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
        cycle(1'b0, 1'b1, a, d);
    endtask

    task automatic rd_check(input logic [1:0] a, input logic [31:0] exp, input string tag);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.address    = a;
        #1;
        check(tag, bus.readdata, exp);
    endtask

    task automatic rd_all();
        rd_check(2'd0, {31'b0, m_en}, "rd_ctrl");
        rd_check(2'd1, {24'b0, m_duty}, "rd_duty");
        rd_check(2'd2, {14'b0, m_bmask}, "rd_bmask");
        rd_check(2'd3, {16'b0, m_bper}, "rd_bper");
    endtask

    task automatic wait_strb();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 2 * PERIOD && !seen; i++) begin
            idle();
            seen = last_strb;
        end
        check("strb_seen", {31'b0, seen}, 32'd1);
    endtask

    task automatic count_period(input int b0, input int b1, output int h0, output int h1);
        h0 = 0;
        h1 = 0;
        for (int i = 0; i < PERIOD; i++) begin
            idle();
            if (led_out[b0]) h0++;
            if (led_out[b1]) h1++;
        end
    endtask

    initial begin
        int h0;
        int h1;
        int exp4 [4];
        exp4 = '{510, 0, 0, 510};
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'h0;
        pattern_in     = {WIDTH{1'b1}};
        repeat (3) @(posedge clk);
        #1;

        // 1: defaults, full pattern -> 255/256 duty
        cycle(1'b1, 1'b0, 2'd0, 32'h0);
        rd_all();
        wait_strb();
        count_period(0, 17, h0, h1);
        check("t1_high", h0, 32'd510);

        // 2: duty 64 written mid-period
        repeat (100) idle();
        wr_reg(2'd1, 32'hABCD_0040);
        rd_all();
        wait_strb();
        count_period(0, 17, h0, h1);
        check("t2_high", h0, 32'd128);

        // 3: duty 0, then enable cleared with duty 255
        wr_reg(2'd1, 32'h0);
        wait_strb();
        count_period(0, 17, h0, h1);
        check("t3_off", h0 + h1, 32'd0);
        wr_reg(2'd1, 32'hFF);
        wait_strb();
        repeat (10) idle();
        wr_reg(2'd0, 32'hFFFF_FFFE);
        idle();
        check("t3_en_off", {14'b0, led_out}, 32'h0);
        rd_all();
        wr_reg(2'd0, 32'h1);

        // 4: blink bit 0 with half-period 2
        wr_reg(2'd2, 32'hFFFC_0001);
        wr_reg(2'd3, 32'hFFFF_0002);
        rd_all();
        wait_strb();
        for (int p = 0; p < 4; p++) begin
            count_period(0, 1, h0, h1);
            check("t4_bit0", h0, exp4[p]);
            check("t4_bit1", h1, 32'd510);
        end
        wr_reg(2'd3, 32'h0);
        wait_strb();
        count_period(0, 1, h0, h1);
        check("t4_steady", h0, 32'd510);

        // 5: pattern change mid-period is held until the boundary
        repeat (100) idle();
        pattern_in = 18'h0000F;
        repeat (5) idle();
        check("t5_hold", {31'b0, led_out[17]}, 32'd1);
        wait_strb();
        count_period(0, 17, h0, h1);
        check("t5_bit0", h0, 32'd510);
        check("t5_bit17", h1, 32'd0);

        // 6: reset mid-period, then DUTY written on a boundary cycle
        repeat (50) idle();
        cycle(1'b1, 1'b0, 2'd0, 32'h0);
        check("t6_strb", {31'b0, period_strb}, 32'd0);
        rd_all();
        while (!model_bnd()) idle();
        wr_reg(2'd1, 32'h10);
        rd_check(2'd1, 32'h10, "t6_rd_duty");
        count_period(0, 17, h0, h1);
        check("t6_late", h0, 32'd510);
        count_period(0, 17, h0, h1);
        check("t6_new", h0, 32'd32);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [1:0]  a;
            logic [31:0] d;
            if ($urandom_range(0, 63) == 0) pattern_in = WIDTH'($urandom);
            if ($urandom_range(0, 1999) == 0) begin
                cycle(1'b1, 1'b0, 2'd0, 32'h0);
            end else if ($urandom_range(0, 15) == 0) begin
                a = 2'($urandom_range(0, 3));
                d = $urandom;
                if (a == 2'd3) d = {16'($urandom), 16'($urandom_range(0, 3))};
                if (a == 2'd0) d[0] = ($urandom_range(0, 3) != 0);
                wr_reg(a, d);
                rd_all();
            end else begin
                idle();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
